// File: rtl/xor_response_checker.sv
// Response-side checker for 2-input gate characterisation: compares observed c against
// a truth table, tracks input coverage and error counts, and reports a pass/fail verdict.
module xor_response_checker #(
  parameter logic [3:0] TRUTH       = 4'b0110,
  parameter int         CNT_W       = 8,
  parameter int         MAX_SAMPLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [3:0]       cov,
  output logic [CNT_W-1:0] sample_count,
  output logic [CNT_W-1:0] err_count,
  output logic             fail_valid,
  output logic [2:0]       fail_vec
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_SAMPLES);

  state_t           state_q, state_d;
  logic [3:0]       cov_q, cov_d;
  logic [CNT_W-1:0] sample_count_q, sample_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic             fail_valid_q, fail_valid_d;
  logic [2:0]       fail_vec_q, fail_vec_d;

  logic [1:0] idx;
  logic       mismatch;
  logic       accept;

  always_comb begin
    state_d        = state_q;
    cov_d          = cov_q;
    sample_count_d = sample_count_q;
    err_count_d    = err_count_q;
    fail_valid_d   = fail_valid_q;
    fail_vec_d     = fail_vec_q;
    idx            = {a, b};
    mismatch       = (c != TRUTH[idx]);
    accept         = in_valid && (state_q == S_RUN);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d        = S_RUN;
          cov_d          = 4'h0;
          sample_count_d = '0;
          err_count_d    = '0;
          fail_valid_d   = 1'b0;
          fail_vec_d     = 3'b000;
        end
      end
      S_RUN: begin
        if (accept) begin
          cov_d[idx]     = 1'b1;
          sample_count_d = sample_count_q + CNT_W'(1);
          if (mismatch) begin
            if (err_count_q != '1) err_count_d = err_count_q + CNT_W'(1);
            if (!fail_valid_q) begin
              fail_valid_d = 1'b1;
              fail_vec_d   = {a, b, c};
            end
          end
          // Exit decisions use the post-update values so the final sample counts.
          if (cov_d == 4'hF || sample_count_d == MAX_C) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cov_q          <= 4'h0;
      sample_count_q <= '0;
      err_count_q    <= '0;
      fail_valid_q   <= 1'b0;
      fail_vec_q     <= 3'b000;
    end else begin
      state_q        <= state_d;
      cov_q          <= cov_d;
      sample_count_q <= sample_count_d;
      err_count_q    <= err_count_d;
      fail_valid_q   <= fail_valid_d;
      fail_vec_q     <= fail_vec_d;
    end
  end

  assign in_ready     = (state_q == S_RUN);
  assign busy         = (state_q == S_RUN);
  assign done         = (state_q == S_DONE);
  assign pass         = (state_q == S_DONE) && (err_count_q == '0) && (cov_q == 4'hF);
  assign cov          = cov_q;
  assign sample_count = sample_count_q;
  assign err_count    = err_count_q;
  assign fail_valid   = fail_valid_q;
  assign fail_vec     = fail_vec_q;

endmodule

// File: tb/tb_xor_response_checker.sv
// Directed table-driven bench for xor_response_checker: default XOR instance, a
// short-budget instance, and a narrow-counter XNOR instance.
module tb_xor_response_checker;

  typedef struct packed {
    logic       busy;
    logic       rdy;
    logic       done;
    logic       pass;
    logic [3:0] cov;
    logic [7:0] sc;
    logic [7:0] ec;
    logic       fv;
    logic [2:0] fvec;
  } obs_t;

  typedef struct {
    logic       st;
    logic       v;
    logic [2:0] abc;
    obs_t       exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic in_valid = 1'b0;
  logic a = 1'b0, b = 1'b0, c = 1'b0;

  logic       rdy0, busy0, done0, pass0, fv0;
  logic [3:0] cov0;
  logic [7:0] sc0, ec0;
  logic [2:0] fvec0;

  logic       rdy1, busy1, done1, pass1, fv1;
  logic [3:0] cov1;
  logic [7:0] sc1, ec1;
  logic [2:0] fvec1;

  logic       rdy2, busy2, done2, pass2, fv2;
  logic [3:0] cov2;
  logic [1:0] sc2, ec2;
  logic [2:0] fvec2;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  xor_response_checker u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .in_valid(in_valid), .in_ready(rdy0),
    .a(a), .b(b), .c(c), .busy(busy0), .done(done0), .pass(pass0), .cov(cov0),
    .sample_count(sc0), .err_count(ec0), .fail_valid(fv0), .fail_vec(fvec0)
  );

  xor_response_checker #(.MAX_SAMPLES(6)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .in_valid(in_valid), .in_ready(rdy1),
    .a(a), .b(b), .c(c), .busy(busy1), .done(done1), .pass(pass1), .cov(cov1),
    .sample_count(sc1), .err_count(ec1), .fail_valid(fv1), .fail_vec(fvec1)
  );

  xor_response_checker #(.TRUTH(4'b1001), .CNT_W(2), .MAX_SAMPLES(3)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .in_valid(in_valid), .in_ready(rdy2),
    .a(a), .b(b), .c(c), .busy(busy2), .done(done2), .pass(pass2), .cov(cov2),
    .sample_count(sc2), .err_count(ec2), .fail_valid(fv2), .fail_vec(fvec2)
  );

  function automatic obs_t mko(input logic bsy, input logic rd, input logic dn, input logic ps,
                               input logic [3:0] cv, input int sc, input int ec,
                               input logic fv, input logic [2:0] fvec);
    obs_t o;
    o.busy = bsy; o.rdy = rd; o.done = dn; o.pass = ps; o.cov = cv;
    o.sc = 8'(sc); o.ec = 8'(ec); o.fv = fv; o.fvec = fvec;
    return o;
  endfunction

  function automatic obs_t obs0();
    return mko(busy0, rdy0, done0, pass0, cov0, int'(sc0), int'(ec0), fv0, fvec0);
  endfunction
  function automatic obs_t obs1();
    return mko(busy1, rdy1, done1, pass1, cov1, int'(sc1), int'(ec1), fv1, fvec1);
  endfunction
  function automatic obs_t obs2();
    return mko(busy2, rdy2, done2, pass2, cov2, int'(sc2), int'(ec2), fv2, fvec2);
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got busy=%b rdy=%b done=%b pass=%b cov=%h sc=%0d ec=%0d fv=%b fvec=%b ; want busy=%b rdy=%b done=%b pass=%b cov=%h sc=%0d ec=%0d fv=%b fvec=%b",
               name, act.busy, act.rdy, act.done, act.pass, act.cov, act.sc, act.ec, act.fv, act.fvec,
               exp.busy, exp.rdy, exp.done, exp.pass, exp.cov, exp.sc, exp.ec, exp.fv, exp.fvec);
    end
  endtask

  task automatic step(input logic s0, input logic s1, input logic s2, input logic v,
                      input logic [2:0] abc);
    start0 = s0; start1 = s1; start2 = s2; in_valid = v;
    {a, b, c} = abc;
    @(posedge clk);
    #1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0; in_valid = 1'b0;
  endtask

  vec_t tbl[17];
  obs_t z;

  initial begin
    z = mko(0, 0, 0, 0, 4'h0, 0, 0, 0, 3'b000);
    //                  st  v   abc            busy rdy done pass cov   sc ec fv fvec
    tbl[0]  = '{1'b0, 1'b1, 3'b001, mko(0, 0, 0, 0, 4'h0, 0, 0, 0, 3'b000)};
    tbl[1]  = '{1'b1, 1'b0, 3'b000, mko(1, 1, 0, 0, 4'h0, 0, 0, 0, 3'b000)};
    tbl[2]  = '{1'b0, 1'b1, 3'b000, mko(1, 1, 0, 0, 4'h1, 1, 0, 0, 3'b000)};
    tbl[3]  = '{1'b0, 1'b1, 3'b011, mko(1, 1, 0, 0, 4'h3, 2, 0, 0, 3'b000)};
    tbl[4]  = '{1'b0, 1'b0, 3'b111, mko(1, 1, 0, 0, 4'h3, 2, 0, 0, 3'b000)};
    tbl[5]  = '{1'b1, 1'b1, 3'b101, mko(1, 1, 0, 0, 4'h7, 3, 0, 0, 3'b000)};
    tbl[6]  = '{1'b0, 1'b1, 3'b110, mko(0, 0, 1, 1, 4'hF, 4, 0, 0, 3'b000)};
    tbl[7]  = '{1'b0, 1'b1, 3'b001, mko(0, 0, 1, 1, 4'hF, 4, 0, 0, 3'b000)};
    tbl[8]  = '{1'b1, 1'b0, 3'b000, mko(1, 1, 0, 0, 4'h0, 0, 0, 0, 3'b000)};
    tbl[9]  = '{1'b0, 1'b1, 3'b000, mko(1, 1, 0, 0, 4'h1, 1, 0, 0, 3'b000)};
    tbl[10] = '{1'b0, 1'b1, 3'b111, mko(1, 1, 0, 0, 4'h9, 2, 1, 1, 3'b111)};
    tbl[11] = '{1'b0, 1'b1, 3'b001, mko(1, 1, 0, 0, 4'h9, 3, 2, 1, 3'b111)};
    tbl[12] = '{1'b0, 1'b1, 3'b011, mko(1, 1, 0, 0, 4'hB, 4, 2, 1, 3'b111)};
    tbl[13] = '{1'b0, 1'b1, 3'b101, mko(0, 0, 1, 0, 4'hF, 5, 2, 1, 3'b111)};
    tbl[14] = '{1'b1, 1'b0, 3'b000, mko(1, 1, 0, 0, 4'h0, 0, 0, 0, 3'b000)};
    tbl[15] = '{1'b0, 1'b1, 3'b000, mko(1, 1, 0, 0, 4'h1, 1, 0, 0, 3'b000)};
    tbl[16] = '{1'b0, 1'b1, 3'b011, mko(1, 1, 0, 0, 4'h3, 2, 0, 0, 3'b000)};

    // Reset state of all instances.
    @(posedge clk); #1;
    check("reset_dut0", obs0(), z);
    check("reset_dut1", obs1(), z);
    check("reset_dut2", obs2(), z);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      step(tbl[i].st, 1'b0, 1'b0, tbl[i].v, tbl[i].abc);
      check($sformatf("tbl[%0d]", i), obs0(), tbl[i].exp);
    end

    // Asynchronous reset mid-cycle after two accepted samples.
    #2 rst = 1'b1;
    #1 check("async_rst_immediate", obs0(), z);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    check("after_rst_idle", obs0(), z);
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
    step(1'b0, 1'b0, 1'b0, 1'b1, 3'b000);
    step(1'b0, 1'b0, 1'b0, 1'b1, 3'b011);
    step(1'b0, 1'b0, 1'b0, 1'b1, 3'b101);
    step(1'b0, 1'b0, 1'b0, 1'b1, 3'b110);
    check("rerun_after_rst", obs0(), mko(0, 0, 1, 1, 4'hF, 4, 0, 0, 3'b000));

    // Budget exit with MAX_SAMPLES=6 and only {a,b}=00 covered.
    step(1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
    for (int k = 1; k <= 6; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 3'b000);
      if (k < 6) check($sformatf("budget6_s%0d", k), obs1(), mko(1, 1, 0, 0, 4'h1, k, 0, 0, 3'b000));
      else       check("budget6_done", obs1(), mko(0, 0, 1, 0, 4'h1, 6, 0, 0, 3'b000));
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 3'b001);
    check("budget6_hold", obs1(), mko(0, 0, 1, 0, 4'h1, 6, 0, 0, 3'b000));

    // Narrow counters, XNOR truth table, budget of 3.
    step(1'b0, 1'b0, 1'b1, 1'b0, 3'b000);
    step(1'b0, 1'b0, 1'b0, 1'b1, 3'b001);
    step(1'b0, 1'b0, 1'b0, 1'b1, 3'b010);
    check("xnor_mid", obs2(), mko(1, 1, 0, 0, 4'h3, 2, 0, 0, 3'b000));
    step(1'b0, 1'b0, 1'b0, 1'b1, 3'b100);
    check("xnor_done", obs2(), mko(0, 0, 1, 0, 4'h7, 3, 0, 0, 3'b000));
    step(1'b0, 1'b0, 1'b1, 1'b0, 3'b000);
    check("xnor_restart", obs2(), mko(1, 1, 0, 0, 4'h0, 0, 0, 0, 3'b000));
    step(1'b0, 1'b0, 1'b0, 1'b1, 3'b110);
    check("xnor_mismatch", obs2(), mko(1, 1, 0, 0, 4'h8, 1, 1, 1, 3'b110));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
